operand_display: RTL and testbench
==================================

# operand_display

Time-multiplexed four-digit seven-segment driver that reads the two 3-bit operand registers (`in1`, `in2`) produced by the button-capture stage and displays them on the board display, together with their decimal sum. It consumes what the capture stage writes. It owns the refresh prescaler, the digit-scan state machine, the frame-boundary operand snapshot and the anti-ghosting blanking. All outputs are registered and drive the board pins directly.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit period; legal range 4..65535.
- `BLANK_CYCLES`, 500: cycles at the start of each digit period during which all anodes are off; legal range 1..`REFRESH_DIV`-2.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in1`  input  3  operand A, unsigned 0..7, from the capture stage.
- `in2`  input  3  operand B, unsigned 0..7, from the capture stage.
- `an`  output  4  digit anodes, active-low; `an[3]` is the leftmost digit.
- `seg`  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- Prescaler `cnt` counts 0..`REFRESH_DIV`-1, then wraps to 0. `tick` is asserted when `cnt`==`REFRESH_DIV`-1.
- Scan FSM states: DIG3 → DIG2 → DIG1 → DIG0 → DIG3. The FSM advances only on `tick`.
- Digit content:
  - DIG3 shows `snap1`.
  - DIG2 shows `snap2`.
  - DIG1 shows the tens digit of `snap1`+`snap2` (0 or 1).
  - DIG0 shows the units digit (0..9).
- Sum arithmetic:
  - Sum is 4-bit unsigned, 0..14, and cannot overflow.
  - Tens = (sum ≥ 10). Units = sum − 10·tens.
- Snapshot:
  - `snap1`/`snap2` load `in1`/`in2` on the `tick` that moves DIG0 → DIG3.
  - Operand changes within a frame are not shown until the next frame, so there is no tearing between the operand digits and the sum digits.
- Blanking: while `cnt` < `BLANK_CYCLES`, `an`=4'b1111. Otherwise, the anode of the current digit is low and all others are high.
- Segment codes (active-low gfedcba):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - blank=7'h7F
- Reset (asynchronous): `cnt`=0, state=DIG3, `snap1`=`snap2`=0, `an`=4'b1111, `seg`=7'h7F.
  - Reset asserted mid-frame aborts the frame immediately.
  - The first frame after release displays 0,0,0,0, or blank on DIG1 when `OPERAND_DISPLAY_LZB_EN` is defined.

## Timing
- `an` and `seg` are registered from (state, `cnt`, snapshot), with 1-cycle latency.
- First cycle after reset release: `cnt`=0, DIG3, outputs still blank.
- DIG3 anode goes low at the clock edge after the one where `cnt` reaches `BLANK_CYCLES`.
- Frame length is exactly 4·`REFRESH_DIV` cycles.
- A new `in1`/`in2` value appears on DIG3 one frame plus one cycle, at most, after the snapshot tick that samples it.
- If `in1`/`in2` change on the same edge as the snapshot tick, the value present before that edge is captured.

## Configuration
- `OPERAND_DISPLAY_LZB_EN` defined: leading-zero blanking on the sum. When tens==0, DIG1 drives `seg`=7'h7F, and its anode still follows the normal scan.
- Macro undefined: DIG1 always shows the tens digit, including 0 (7'h40).
- No other behaviour differs.

## Structure
- Package `operand_display_pkg`:
  - 2-bit digit-state encoding (DIG3=2'd3 … DIG0=2'd0).
  - Segment constants `SEG_0`…`SEG_9` and `SEG_BLANK`.
- Sub-module `bcd_to_seg`: combinational 4-bit → 7-bit decoder. Inputs above 9 map to `SEG_BLANK`.
- Top contains: prescaler, FSM, snapshot registers, sum/split logic, output registers.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2.
- Reset held, then released with `in1`=5, `in2`=6:
  - Frame 1: DIG3..DIG0 seg = 40,40,40,40 (LZB undefined).
  - Frame 2: seg = 12,02,79,79 (5, 6, 1, 1).
  - `an` high during reset.
- `in1`=7, `in2`=7 steady: sum digits show 1,4 (7'h79, 7'h19) and each anode is low for exactly 6 of every 8 cycles.
- `in1`=3, `in2`=2 with `OPERAND_DISPLAY_LZB_EN` defined: DIG1 seg=7'h7F with `an`=4'b1101, and DIG0 seg=7'h12. Without the macro, DIG1 seg=7'h40.
- Change `in1` from 1 to 4 during DIG2:
  - DIG3/DIG0 keep showing 1 and the old sum for the rest of the frame.
  - The next frame shows 4 and the new sum.
- Assert reset for 1 cycle while DIG1 is active: `an`=4'b1111 and `seg`=7'h7F asynchronously, and the scan restarts at DIG3 with `cnt`=0.
- Count cycles across 3 frames: `an` pattern period is 32 cycles, in the order 0111, 1011, 1101, 1110, each preceded by 2 cycles of 1111.

Source files
------------

// File: rtl/operand_display_pkg.sv
// Shared types and constants for the four-digit operand/sum display.
package operand_display_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SEG_W = 7;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/operand_display_bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 blank the digit.
module bcd_to_seg
  import operand_display_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/operand_display.sv
// Four-digit multiplexed display of two 3-bit operands and their decimal sum.
// Define OPERAND_DISPLAY_LZB_EN to blank the sum's tens digit when it is zero.
module operand_display
  import operand_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  output logic [3:0] an,
  output logic [6:0] seg
);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  digit_e           state;
  digit_e           state_next;
  logic [2:0]       snap1;
  logic [2:0]       snap2;
  logic [3:0]       sum;
  logic             tens;
  logic [3:0]       units;
  logic [3:0]       digit;
  logic [SEG_W-1:0] seg_d;
  logic [3:0]       an_d;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  // Digit-period prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIG3;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        DIG3:    state_next = DIG2;
        DIG2:    state_next = DIG1;
        DIG1:    state_next = DIG0;
        DIG0:    state_next = DIG3;
        default: state_next = DIG3;
      endcase
    end
  end

  // Operands are frozen for a whole frame so operand and sum digits always agree
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap1 <= '0;
      snap2 <= '0;
    end else if (tick && (state == DIG0)) begin
      snap1 <= in1;
      snap2 <= in2;
    end
  end

  assign sum   = 4'(snap1) + 4'(snap2);
  assign tens  = (sum >= 4'd10);
  assign units = tens ? (sum - 4'd10) : sum;

  always_comb begin
    digit = 4'hF;
    case (state)
      DIG3: digit = 4'(snap1);
      DIG2: digit = 4'(snap2);
`ifdef OPERAND_DISPLAY_LZB_EN
      DIG1: digit = tens ? 4'd1 : 4'hF;
`else
      DIG1: digit = 4'(tens);
`endif
      DIG0:    digit = units;
      default: digit = 4'hF;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd   (digit),
    .seg_c (seg_d)
  );

  assign an_d = (cnt < CNT_W'(BLANK_CYCLES)) ? 4'b1111 : ~(4'b0001 << state);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_operand_display.sv
// Self-checking bench: frame-level reference model of the operand/sum display.
module tb_operand_display;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] in1 = 3'd0;
  logic [2:0] in2 = 3'd0;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int failures = 0;
  int e = 0;
  int ms1 = 0;
  int ms2 = 0;
  int low_cnt [4];

  logic [6:0] enc_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  operand_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .in1   (in1),
    .in2   (in2),
    .an    (an),
    .seg   (seg)
  );

  function automatic logic [6:0] enc(int v);
    if (v > 9) return 7'h7F;
    return enc_tbl[v];
  endfunction

  function automatic logic [6:0] exp_seg(int d, int s1, int s2);
    int sum;
    sum = s1 + s2;
    case (d)
      3: return enc(s1);
      2: return enc(s2);
`ifdef OPERAND_DISPLAY_LZB_EN
      1: return (sum / 10 == 0) ? 7'h7F : enc(sum / 10);
`else
      1: return enc(sum / 10);
`endif
      default: return enc(sum % 10);
    endcase
  endfunction

  task automatic check_an(string tag, logic [3:0] exp);
    checks++;
    assert (an === exp) else begin
      failures++;
      $error("FAIL %s an=%b expected %b (e=%0d)", tag, an, exp, e);
    end
  endtask

  task automatic check_seg(string tag, logic [6:0] exp);
    checks++;
    assert (seg === exp) else begin
      failures++;
      $error("FAIL %s seg=%h expected %h (e=%0d)", tag, seg, exp, e);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: predict the registered outputs from the position after e edges
  task automatic step();
    int pos, d, p1, p2;
    logic [3:0] ea;
    logic [6:0] es;
    pos = e % RD;
    d   = 3 - ((e / RD) % 4);
    ea  = (pos < BC) ? 4'b1111 : ~(4'b0001 << d);
    es  = exp_seg(d, ms1, ms2);
    p1  = int'(in1);
    p2  = int'(in2);
    @(posedge clk);
    #1;
    check_an("scan_an", ea);
    check_seg("scan_seg", es);
    for (int i = 0; i < 4; i++) if (!an[i]) low_cnt[i]++;
    e++;
    if (e % FRAME == 0) begin
      ms1 = p1;
      ms2 = p2;
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic restart_model();
    e = 0;
    ms1 = 0;
    ms2 = 0;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    in1 = 3'd5;
    in2 = 3'd6;
    repeat (3) @(posedge clk);
    #1;
    check_an("reset_an", 4'b1111);
    check_seg("reset_seg", 7'h7F);
    reset = 1'b0;
    restart_model();
    #1;
    check_an("release_an", 4'b1111);
    check_seg("release_seg", 7'h7F);
    run(2 * FRAME);

    in1 = 3'd7;
    in2 = 3'd7;
    run(FRAME);
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    run(FRAME);
    for (int i = 0; i < 4; i++) check_int($sformatf("an_low_d%0d", i), low_cnt[i], RD - BC);

    in1 = 3'd3;
    in2 = 3'd2;
    run(2 * FRAME);

    in1 = 3'd1;
    in2 = 3'd0;
    run(FRAME - (e % FRAME));
    run(FRAME);
    run(RD + 3);
    in1 = 3'd4;
    run(2 * FRAME - (RD + 3));

    guard = 0;
    while ((e % FRAME) != (2 * RD + 4) && guard < FRAME) begin
      step();
      guard++;
    end
    check_int("dig1_reach", e % FRAME, 2 * RD + 4);
    #2;
    reset = 1'b1;
    #1;
    check_an("async_rst_an", 4'b1111);
    check_seg("async_rst_seg", 7'h7F);
    @(posedge clk);
    #1;
    check_an("held_rst_an", 4'b1111);
    check_seg("held_rst_seg", 7'h7F);
    reset = 1'b0;
    restart_model();
    run(FRAME + RD);

    repeat (20) begin
      in1 = 3'($urandom_range(0, 7));
      in2 = 3'($urandom_range(0, 7));
      run(int'($urandom_range(1, 60)));
    end
    run(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
